// File: rtl/dmem_responder_if.sv
// D-cache request/response types and the handshake bundle that carries them.
// Latency: none, wires only. Backpressure: dcache_req.ready gates responses, dcache_res.ready gates requests.
// Ports: master drives dcache_req and samples dcache_res; slave does the reverse.

package dmem_responder_pkg;

  typedef enum logic [1:0] {
    NO_SIZE = 2'd0,
    BYTE    = 2'd1,
    HALF    = 2'd2,
    WORD    = 2'd3
  } rw_size_e;

  // Request from the memory stage. 'ready' travels with the request but
  // means "requester can take a response this cycle".
  typedef struct packed {
    logic        valid;
    logic        ready;
    logic [31:0] addr;
    logic        rw;        // 1 = store
    rw_size_e    rw_size;
    logic [31:0] data;      // store data, low-aligned
    logic        uncached;
  } dcache_req_t;

  // Response to the memory stage. 'ready' means "responder can accept a
  // request this cycle".
  typedef struct packed {
    logic        valid;
    logic        ready;
    logic [31:0] data;
  } dcache_res_t;

endpackage

interface dmem_responder_if;
  import dmem_responder_pkg::*;

  dcache_req_t dcache_req;
  dcache_res_t dcache_res;

  modport master (output dcache_req, input dcache_res);
  modport slave  (input dcache_req, output dcache_res);
endinterface

// File: rtl/dmem_responder.sv
// Tightly-coupled data RAM answering each D-cache request with exactly one response.
// Latency: response valid LATENCY cycles after acceptance. Backpressure: response held until req.ready; one transaction in flight.
// Ports: clk_i, rst_i (sync, active-high), dcache (slave side of dmem_responder_if), access_fault_o, proto_err_o (sticky).

module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,          // power of two, >= 2
  parameter logic [31:0] BASE_ADDR   = 32'h2000_0000, // aligned to DEPTH_WORDS*4
  parameter int          LATENCY     = 1              // 1..8
) (
  input  logic            clk_i,
  input  logic            rst_i,
  dmem_responder_if.slave dcache,
  output logic            access_fault_o,
  output logic            proto_err_o
);

  localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  // WAIT is entered with LATENCY-2 and leaves when the count reaches zero,
  // which places the first RESP cycle exactly LATENCY cycles after acceptance.
  localparam logic [2:0] CNT_INIT = (LATENCY >= 2) ? 3'(LATENCY - 2) : 3'd0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] data_q, data_d;
  logic        fault_q, fault_d;
  logic        perr_q, perr_d;

  logic [31:0] mem [DEPTH_WORDS];

  dcache_req_t req;
  dcache_res_t res;

  assign req = dcache.dcache_req;

  // The uncached hint has no meaning for a RAM that is always the backing store.
  logic unused_bits;
  assign unused_bits = req.uncached;

  // ------------------------------------------------------------------
  // Request decode
  // ------------------------------------------------------------------
  logic [31:0]   off;
  logic          in_range;
  logic [AW-1:0] idx;
  logic [1:0]    lane;
  logic          req_fault;
  logic [3:0]    strb;
  logic [31:0]   wdata;
  logic          accept;
  logic          we;

  // Subtracting the base wraps addresses below BASE_ADDR to huge offsets,
  // so one unsigned bound covers both ends of the window.
  assign off      = req.addr - BASE_ADDR;
  assign in_range = ((off >> (AW + 2)) == 32'd0);
  assign idx      = off[AW+1:2];
  assign lane     = req.addr[1:0];

  always_comb begin
    req_fault = !in_range;
    case (req.rw_size)
      BYTE:    req_fault = !in_range;
      HALF:    if (req.addr[0]) req_fault = 1'b1;
      WORD:    if (req.addr[1:0] != 2'b00) req_fault = 1'b1;
      default: req_fault = 1'b1;  // NO_SIZE
    endcase
  end

  // Store data arrives in the low bytes; move it to the addressed lanes.
  always_comb begin
    strb = 4'b0000;
    case (req.rw_size)
      BYTE:    strb = 4'b0001 << lane;
      HALF:    strb = 4'b0011 << lane;
      WORD:    strb = 4'b1111;
      default: strb = 4'b0000;
    endcase
  end

  assign wdata  = req.data << {lane, 3'b000};
  assign accept = (state_q == ST_IDLE) && req.valid;
  // Reset on the same edge cancels the acceptance, including its write.
  assign we     = accept && req.rw && !req_fault && !rst_i;

  // ------------------------------------------------------------------
  // RAM: byte-lane writes, contents survive reset
  // ------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (strb[b]) begin
          mem[idx][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
  end

  // ------------------------------------------------------------------
  // Transaction FSM
  // ------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
      fault_q <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      fault_q <= fault_d;
      perr_q  <= perr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    fault_d = fault_q;
    perr_d  = perr_q;

    case (state_q)
      ST_IDLE: begin
        if (req.valid) begin
          fault_d = req_fault;
          // Loads sample the RAM on the acceptance edge, so any store accepted
          // earlier is already visible. Stores and faults answer with zero.
          data_d  = (req.rw || req_fault) ? 32'd0 : mem[idx];
          if (LATENCY == 1) begin
            state_d = ST_RESP;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end

      ST_WAIT: begin
        if (cnt_q == 3'd0) begin
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
        // Request while busy: dropped, flagged, in-flight one untouched.
        if (req.valid) perr_d = 1'b1;
      end

      ST_RESP: begin
        if (req.ready) state_d = ST_IDLE;
        if (req.valid) perr_d = 1'b1;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // ------------------------------------------------------------------
  // Outputs
  // ------------------------------------------------------------------
  always_comb begin
    res       = '0;
    res.valid = (state_q == ST_RESP);
    res.ready = (state_q == ST_IDLE);
    res.data  = data_q;
  end

  assign dcache.dcache_res = res;
  assign access_fault_o    = (state_q == ST_RESP) && fault_q;
  assign proto_err_o       = perr_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances at LATENCY 1, 3 and 4 with a transaction-level model.
// Latency: model predicts response-valid at acceptance cycle + LATENCY. Backpressure: driven via req.ready.
// Ports: bench owns one dmem_responder_if per instance.

module tb_dmem_responder;
  import dmem_responder_pkg::*;

  localparam logic [31:0] BASE  = 32'h2000_0000;
  localparam int          DEPTH = 1024;
  localparam int          NDUT  = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dcache_req_t req_drv   [NDUT];
  dcache_res_t res_mon   [NDUT];
  logic        fault_mon [NDUT];
  logic        perr_mon  [NDUT];

  int   n_chk  = 0;
  int   n_fail = 0;
  int   cyc    = 0;
  logic chk_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    dmem_responder_if ifc ();
    assign ifc.dcache_req = req_drv[g];
    assign res_mon[g]     = ifc.dcache_res;

    dmem_responder #(
      .DEPTH_WORDS (DEPTH),
      .BASE_ADDR   (BASE),
      .LATENCY     ((g == 0) ? 1 : ((g == 1) ? 3 : 4))
    ) u_dut (
      .clk_i          (clk),
      .rst_i          (rst),
      .dcache         (ifc),
      .access_fault_o (fault_mon[g]),
      .proto_err_o    (perr_mon[g])
    );
  end

  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : ((k == 1) ? 3 : 4);
  endfunction

  task automatic check(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d: got %h expected %h (cycle %0d)", name, k, act, exp, cyc);
    end
  endtask

  // ------------------------------------------------------------------
  // Transaction-level model: absolute response time + sparse word memory
  // ------------------------------------------------------------------
  bit          pend_m    [NDUT];
  int          resp_at_m [NDUT];
  logic [31:0] rdat_m    [NDUT];
  bit          flt_m     [NDUT];
  bit          perr_m    [NDUT];
  logic [31:0] mem_m     [int];

  function automatic bit model_fault(input logic [31:0] a, input rw_size_e sz);
    longint o;
    o = longint'({32'd0, a}) - longint'({32'd0, BASE});
    if (o < 0 || o >= DEPTH * 4) return 1'b1;
    case (sz)
      BYTE:    return 1'b0;
      HALF:    return (a % 2) != 0;
      WORD:    return (a % 4) != 0;
      default: return 1'b1;
    endcase
  endfunction

  function automatic int nbytes(input rw_size_e sz);
    case (sz)
      BYTE:    return 1;
      HALF:    return 2;
      default: return 4;
    endcase
  endfunction

  task automatic model_accept(input int k);
    dcache_req_t r;
    bit          f;
    int          key;
    int          ln;
    logic [31:0] w;
    r             = req_drv[k];
    f             = model_fault(r.addr, r.rw_size);
    pend_m[k]     = 1'b1;
    resp_at_m[k]  = cyc + lat_of(k);
    flt_m[k]      = f;
    rdat_m[k]     = 32'd0;
    if (!f) begin
      key = k * DEPTH + int'((r.addr - BASE) >> 2);
      w   = mem_m.exists(key) ? mem_m[key] : 32'hxxxx_xxxx;
      if (r.rw) begin
        ln = int'(r.addr[1:0]);
        for (int i = 0; i < nbytes(r.rw_size); i++) begin
          w[8*(ln+i) +: 8] = r.data[8*i +: 8];
        end
        mem_m[key] = w;
      end else begin
        rdat_m[k] = w;
      end
    end
  endtask

  // Compare on the falling edge, then advance the model past the coming edge.
  always @(negedge clk) begin
    for (int k = 0; k < NDUT; k++) begin
      bit ev;
      ev = pend_m[k] && (cyc >= resp_at_m[k]);
      if (chk_en) begin
        check("res_valid",    k, res_mon[k].valid, ev);
        check("res_ready",    k, res_mon[k].ready, !pend_m[k]);
        check("access_fault", k, fault_mon[k],     ev && flt_m[k]);
        check("proto_err",    k, perr_mon[k],      perr_m[k]);
        if (ev) check("res_data", k, res_mon[k].data, rdat_m[k]);
      end
      if (rst) begin
        pend_m[k] = 1'b0;
        perr_m[k] = 1'b0;
      end else if (pend_m[k]) begin
        if (req_drv[k].valid) perr_m[k] = 1'b1;
        if (ev && req_drv[k].ready) pend_m[k] = 1'b0;
      end else if (req_drv[k].valid) begin
        model_accept(k);
      end
    end
  end

  // ------------------------------------------------------------------
  // Stimulus
  // ------------------------------------------------------------------
  // Issues one request from an idle cycle and returns once the handshake is done.
  task automatic xact(input int k, input logic rw, input rw_size_e sz, input logic [31:0] a,
                      input logic [31:0] d, output logic [31:0] rdat, output logic rflt);
    int n;
    req_drv[k].valid   = 1'b1;
    req_drv[k].rw      = rw;
    req_drv[k].rw_size = sz;
    req_drv[k].addr    = a;
    req_drv[k].data    = d;
    @(posedge clk); #1;
    req_drv[k].valid = 1'b0;
    n = 0;
    while (!res_mon[k].valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!res_mon[k].valid) begin
      n_chk++;
      n_fail++;
      $display("FAIL xact_timeout dut%0d: no response within 20 cycles for addr %h", k, a);
    end else begin
      check("latency", k, n + 1, lat_of(k));
    end
    rdat = res_mon[k].data;
    rflt = fault_mon[k];
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic        f;

    for (int k = 0; k < NDUT; k++) begin
      req_drv[k]         = '0;
      req_drv[k].ready   = 1'b1;
      req_drv[k].rw_size = WORD;
    end
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst    = 1'b0;
    chk_en = 1'b1;
    for (int k = 0; k < NDUT; k++) begin
      check("rst_data",  k, res_mon[k].data,  32'd0);
      check("rst_ready", k, res_mon[k].ready, 1'b1);
      check("rst_valid", k, res_mon[k].valid, 1'b0);
    end

    // Word store then load, LATENCY=1
    xact(0, 1'b1, WORD, BASE + 32'h10, 32'hDEAD_BEEF, d, f);
    check("st_word_data", 0, d, 32'd0);
    xact(0, 1'b0, WORD, BASE + 32'h10, 32'd0, d, f);
    check("ld_word_data", 0, d, 32'hDEAD_BEEF);
    check("ld_word_flt",  0, f, 1'b0);

    // Byte-lane merge
    xact(0, 1'b1, WORD, BASE + 32'h20, 32'h0000_0000, d, f);
    xact(0, 1'b1, BYTE, BASE + 32'h21, 32'h0000_0011, d, f);
    xact(0, 1'b1, HALF, BASE + 32'h22, 32'h0000_AABB, d, f);
    xact(0, 1'b0, WORD, BASE + 32'h20, 32'd0, d, f);
    check("merge_data", 0, d, 32'hAABB_1100);
    // Upper store-data bits beyond the size must not leak into other lanes
    xact(0, 1'b1, BYTE, BASE + 32'h23, 32'h1234_5677, d, f);
    xact(0, 1'b0, WORD, BASE + 32'h20, 32'd0, d, f);
    check("merge_byte3", 0, d, 32'h77BB_1100);
    // Sub-word load returns the raw aligned word
    xact(0, 1'b0, BYTE, BASE + 32'h13, 32'd0, d, f);
    check("ld_byte_raw", 0, d, 32'hDEAD_BEEF);

    // Faults
    xact(0, 1'b1, WORD, BASE + 32'h30, 32'h5555_5555, d, f);
    xact(0, 1'b1, HALF, BASE + 32'h31, 32'h0000_FFFF, d, f);
    check("half_mis_flt",  0, f, 1'b1);
    check("half_mis_data", 0, d, 32'd0);
    xact(0, 1'b0, WORD, BASE + 32'h30, 32'd0, d, f);
    check("mem_unchanged", 0, d, 32'h5555_5555);
    check("mem_unch_flt",  0, f, 1'b0);
    xact(0, 1'b0, WORD, BASE - 32'd4, 32'd0, d, f);
    check("below_base_flt",  0, f, 1'b1);
    check("below_base_data", 0, d, 32'd0);
    xact(0, 1'b0, WORD, BASE + 32'd4096, 32'd0, d, f);
    check("above_top_flt", 0, f, 1'b1);
    xact(0, 1'b0, WORD, BASE + 32'h12, 32'd0, d, f);
    check("word_mis_flt", 0, f, 1'b1);
    xact(0, 1'b0, NO_SIZE, BASE + 32'h10, 32'd0, d, f);
    check("no_size_flt", 0, f, 1'b1);

    // Latency and backpressure, LATENCY=3
    xact(1, 1'b1, WORD, BASE + 32'h40, 32'h0BAD_F00D, d, f);
    req_drv[1].valid   = 1'b1;
    req_drv[1].rw      = 1'b0;
    req_drv[1].rw_size = WORD;
    req_drv[1].addr    = BASE + 32'h40;
    for (int i = 1; i <= 7; i++) begin
      @(posedge clk); #1;
      req_drv[1].valid = 1'b0;
      req_drv[1].ready = (i >= 6);
      check("bp_valid", 1, res_mon[1].valid, (i >= 3 && i <= 6));
      check("bp_ready", 1, res_mon[1].ready, (i == 7));
      if (i >= 3 && i <= 6) check("bp_data", 1, res_mon[1].data, 32'h0BAD_F00D);
    end
    req_drv[1].ready = 1'b1;

    // Protocol violation, LATENCY=4
    xact(2, 1'b1, WORD, BASE + 32'h50, 32'hCAFE_F00D, d, f);
    check("perr_clear", 2, perr_mon[2], 1'b0);
    req_drv[2].valid   = 1'b1;
    req_drv[2].rw      = 1'b0;
    req_drv[2].rw_size = WORD;
    req_drv[2].addr    = BASE + 32'h50;
    @(posedge clk); #1;                        // T+1
    req_drv[2].valid = 1'b0;
    @(posedge clk); #1;                        // T+2: illegal store
    req_drv[2].valid = 1'b1;
    req_drv[2].rw    = 1'b1;
    req_drv[2].data  = 32'hFFFF_FFFF;
    @(posedge clk); #1;                        // T+3
    req_drv[2].valid = 1'b0;
    check("perr_rise", 2, perr_mon[2], 1'b1);
    @(posedge clk); #1;                        // T+4
    check("perr_resp_valid", 2, res_mon[2].valid, 1'b1);
    check("perr_resp_data",  2, res_mon[2].data,  32'hCAFE_F00D);
    @(posedge clk); #1;                        // T+5
    check("perr_idle", 2, res_mon[2].ready, 1'b1);
    xact(2, 1'b0, WORD, BASE + 32'h50, 32'd0, d, f);
    check("dropped_store", 2, d, 32'hCAFE_F00D);
    check("perr_sticky",   2, perr_mon[2], 1'b1);
    check("perr_isolated", 0, perr_mon[0], 1'b0);

    // Reset in the middle of a LATENCY=3 load
    req_drv[1].valid   = 1'b1;
    req_drv[1].rw      = 1'b0;
    req_drv[1].rw_size = WORD;
    req_drv[1].addr    = BASE + 32'h40;
    @(posedge clk); #1;                        // T+1
    req_drv[1].valid = 1'b0;
    rst              = 1'b1;
    @(posedge clk); #1;                        // T+2
    rst = 1'b0;
    for (int k = 0; k < NDUT; k++) begin
      check("mrst_valid", k, res_mon[k].valid, 1'b0);
      check("mrst_ready", k, res_mon[k].ready, 1'b1);
      check("mrst_data",  k, res_mon[k].data,  32'd0);
      check("mrst_fault", k, fault_mon[k],     1'b0);
      check("mrst_perr",  k, perr_mon[k],      1'b0);
    end
    repeat (3) begin
      @(posedge clk); #1;
      check("mrst_no_resp", 1, res_mon[1].valid, 1'b0);
    end
    xact(1, 1'b0, WORD, BASE + 32'h40, 32'd0, d, f);
    check("post_rst_data", 1, d, 32'h0BAD_F00D);
    check("post_rst_flt",  1, f, 1'b0);

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
